// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster sequencer.
//   - vga_state_e : scan-out FSM states (idle, running, finishing current frame)
//   - vga_cnt_t   : 10-bit unsigned raster count
//   - Def*        : default 640x480 timing (800 x 528 totals)
//   - to_cnt()    : narrowing helper from elaboration-time integers to vga_cnt_t
package vga_pkg;

  localparam int unsigned CntW   = 10;
  localparam int unsigned CntMax = 1 << CntW;

  typedef logic [CntW-1:0] vga_cnt_t;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } vga_state_e;

  localparam int unsigned DefClkDiv  = 2;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 14;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 32;

  function automatic vga_cnt_t to_cnt(input int unsigned v);
    return vga_cnt_t'(v);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis (horizontal or vertical).
// Wrapping counter 0..Total-1 plus registered sync / active decode. The decode is computed from
// the counter's next value so sync_o and active_o line up with cnt_o in the same clock.
// Ports:
//   clk_i     system clock
//   clr_i     synchronous active-high reset (count 0, sync high, inactive)
//   hold_i    force the axis to its idle condition (count 0, sync high, inactive)
//   adv_i     advance one position this clock
//   cnt_o     current count
//   last_o    count is Total-1
//   wrap_o    advancing from Total-1 back to 0 this clock
//   sync_o    active-low sync, low for count in [SyncStart, SyncStart+SyncLen)
//   active_o  count < Active
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned Total     = 800,
  parameter int unsigned Active    = 640,
  parameter int unsigned SyncStart = 656,
  parameter int unsigned SyncLen   = 96
) (
  input  logic     clk_i,
  input  logic     clr_i,
  input  logic     hold_i,
  input  logic     adv_i,
  output vga_cnt_t cnt_o,
  output logic     last_o,
  output logic     wrap_o,
  output logic     sync_o,
  output logic     active_o
);

  if (Total < 1 || Total > CntMax) begin : g_total_err
    $error("vga_axis_cnt: Total must be in 1..1024");
  end

  localparam vga_cnt_t LastCnt = to_cnt(Total - 1);

  vga_cnt_t    cnt_q, cnt_d;
  logic        sync_q, active_q;
  logic [31:0] cnt_ext;
  logic        in_sync, in_active;

  assign last_o = (cnt_q == LastCnt);
  assign wrap_o = adv_i & last_o;

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last_o ? '0 : cnt_q + 10'd1;
    end
  end

  // Decode on the 32-bit extension so SyncStart+SyncLen may reach 1024 without wrapping.
  always_comb begin
    cnt_ext   = 32'(cnt_d);
    in_sync   = (cnt_ext >= SyncStart) && (cnt_ext < SyncStart + SyncLen);
    in_active = (cnt_ext < Active);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q    <= '0;
      sync_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= hold_i | ~in_sync;
      active_q <= ~hold_i & in_active;
    end
  end

  assign cnt_o    = cnt_q;
  assign sync_o   = sync_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster sequencer.
// Divides clk_i to a one-clock pixel enable, runs the horizontal and vertical scan counters and
// produces sync, blanking and pixel coordinates. Scan-out is started by en_i and, once en_i
// drops, stops only when the last pixel of the last line wraps, so a frame is never truncated.
// Optional build macro: VGA_TIMING_IRQ_EN adds irq_o / irq_ack_i (sticky start-of-vblank flag).
// Ports:
//   clk_i          system clock, all logic on posedge
//   clr_i          synchronous active-high reset, aborts any frame at once
//   en_i           1 = scan out, 0 = stop at the end of the current frame
//   pix_ce_o       pixel clock enable, one clk wide every CLK_DIV clocks while scanning
//   hsync_o        horizontal sync, active low
//   vsync_o        vertical sync, active low
//   video_on_o     inside the visible area
//   px_x_o/px_y_o  current horizontal / vertical count
//   line_end_o     pulse on the pix_ce where the horizontal count wraps
//   frame_start_o  pulse on the pix_ce where the counters become (0,0)
//   busy_o         scanning (running or finishing the current frame)
//   irq_o          (VGA_TIMING_IRQ_EN) sticky, set when the vertical count enters vblank
//   irq_ack_i      (VGA_TIMING_IRQ_EN) clears irq_o; a simultaneous set wins
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic           clk_i,
  input  logic           clr_i,
  input  logic           en_i,
  output logic           pix_ce_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           video_on_o,
  output logic [CntW-1:0] px_x_o,
  output logic [CntW-1:0] px_y_o,
  output logic           line_end_o,
  output logic           frame_start_o,
`ifdef VGA_TIMING_IRQ_EN
  output logic           irq_o,
  input  logic           irq_ack_i,
`endif
  output logic           busy_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CntMax || V_TOTAL > CntMax) begin : g_total_err
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_timing_ctrl: CLK_DIV must be at least 1");
  end

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef logic [DivW-1:0] div_t;
  localparam div_t DivMax = div_t'(CLK_DIV - 1);

  vga_state_e state_q, state_d;
  div_t       div_q, div_d;
  // Set between the start of scan-out and its first pix_ce. That first pix_ce marks pixel (0,0)
  // rather than advancing past it, so every frame lasts exactly CLK_DIV*H_TOTAL*V_TOTAL clocks.
  logic       first_q, first_d;

  logic       tick;
  logic       hold;
  logic       h_adv, h_wrap, h_last, h_sync, h_active;
  logic       v_wrap, v_last, v_sync, v_active;
  logic       frame_end;
  vga_cnt_t   hcnt, vcnt;

  assign tick      = (state_q != StIdle) && (div_q == DivMax);
  assign h_adv     = tick & ~first_q;
  assign frame_end = h_wrap & v_last;
  // Going idle clears divider and counters in the same clock.
  assign hold      = (state_d == StIdle);

  // en_i is only acted on at the final pixel of a frame; elsewhere it just moves between
  // running and stopping without touching the counters.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StRun;
      end
      StRun, StStopping: begin
        if (frame_end && !en_i) begin
          state_d = StIdle;
        end else if (en_i) begin
          state_d = StRun;
        end else begin
          state_d = StStopping;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (state_q == StIdle || state_d == StIdle) begin
      div_d = '0;
    end else if (div_q == DivMax) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    first_d = first_q;
    if (state_d == StIdle) begin
      first_d = 1'b0;
    end else if (state_q == StIdle) begin
      first_d = 1'b1;
    end else if (tick) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      first_q <= first_d;
    end
  end

  vga_axis_cnt #(
    .Total     (H_TOTAL),
    .Active    (H_ACTIVE),
    .SyncStart (H_ACTIVE + H_FP),
    .SyncLen   (H_SYNC)
  ) u_h_axis (
    .clk_i    (clk_i),
    .clr_i    (clr_i),
    .hold_i   (hold),
    .adv_i    (h_adv),
    .cnt_o    (hcnt),
    .last_o   (h_last),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .active_o (h_active)
  );

  vga_axis_cnt #(
    .Total     (V_TOTAL),
    .Active    (V_ACTIVE),
    .SyncStart (V_ACTIVE + V_FP),
    .SyncLen   (V_SYNC)
  ) u_v_axis (
    .clk_i    (clk_i),
    .clr_i    (clr_i),
    .hold_i   (hold),
    .adv_i    (h_wrap),
    .cnt_o    (vcnt),
    .last_o   (v_last),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync),
    .active_o (v_active)
  );

`ifdef VGA_TIMING_IRQ_EN
  localparam vga_cnt_t VBlankPrev = to_cnt(V_ACTIVE - 1);

  logic irq_q, irq_set;

  // The line wrap that moves vcnt from V_ACTIVE-1 to V_ACTIVE is the start of vblank.
  assign irq_set = h_wrap & ~v_last & (vcnt == VBlankPrev) & ~hold;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_set | (irq_q & ~irq_ack_i);
    end
  end

  assign irq_o = irq_q;
`endif

  assign pix_ce_o      = tick;
  assign line_end_o    = h_wrap;
  assign frame_start_o = tick & (first_q | frame_end);
  assign busy_o        = (state_q != StIdle);
  assign hsync_o       = h_sync;
  assign vsync_o       = v_sync;
  assign video_on_o    = h_active & v_active;
  assign px_x_o        = hcnt;
  assign px_y_o        = vcnt;

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a reduced raster (15 x 11, CLK_DIV 2, 330 clk per frame).
// Reference model: scan position is derived arithmetically from the clock count since start.
module tb_vga_timing_ctrl;

  localparam int D  = 2;
  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = D * HT * VT;

  logic       clk = 1'b0;
  logic       clr, en;
  logic       pix_ce, hsync, vsync, video_on, line_end, frame_start, busy;
  logic [9:0] px_x, px_y;
`ifdef VGA_TIMING_IRQ_EN
  logic       irq, irq_ack;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .CLK_DIV (D),  .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF),    .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk_i         (clk),
    .clr_i         (clr),
    .en_i          (en),
    .pix_ce_o      (pix_ce),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .video_on_o    (video_on),
    .px_x_o        (px_x),
    .px_y_o        (px_y),
    .line_end_o    (line_end),
    .frame_start_o (frame_start),
`ifdef VGA_TIMING_IRQ_EN
    .irq_o         (irq),
    .irq_ack_i     (irq_ack),
`endif
    .busy_o        (busy)
  );

  typedef struct packed {
    logic       pce, hs, vs, von;
    logic [9:0] x, y;
    logic       le, fs, busy;
  } obs_t;

  typedef struct {
    logic clr, en;
    int   n;
    int   x, y;
    logic busy, hs, vs, von, pce, fs, le;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_s = clocks elapsed since the clock edge that started scan-out.
  bit m_run = 1'b0;
  int m_s   = 0;
  bit m_irq = 1'b0;

  int cyc_n = 0, fs_prev = -1, fs_gap = -1, fs_cnt = 0;

  function automatic int m_ticks();
    return m_s / D;
  endfunction

  // Frame-relative pixel index; the first pix_ce after start shows pixel 0 and does not move on.
  function automatic int m_pf();
    int t;
    t = m_ticks();
    return ((t > 0) ? t - 1 : 0) % (HT * VT);
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int   pf, x, y, t;
    bit   tk;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (!m_run) return o;
    t  = m_ticks();
    pf = m_pf();
    x  = pf % HT;
    y  = pf / HT;
    tk = (m_s % D) == D - 1;
    o.busy = 1'b1;
    o.pce  = tk;
    o.fs   = tk && (t == 0 || pf == HT * VT - 1);
    o.le   = tk && t > 0 && x == HT - 1;
    o.x    = 10'(x);
    o.y    = 10'(y);
    o.hs   = !(x >= HA + HF && x < HA + HF + HS);
    o.vs   = !(y >= VA + VF && y < VA + VF + VS);
    o.von  = x < HA && y < VA;
    return o;
  endfunction

  task automatic model_step(input logic c, input logic e, input logic a);
    int pf_old;
    bit run_old, tk, set;
    if (c) begin
      m_run = 1'b0; m_s = 0; m_irq = 1'b0;
      return;
    end
    run_old = m_run;
    pf_old  = m_pf();
    tk      = (m_s % D) == D - 1;
    if (!m_run) begin
      if (e) begin m_run = 1'b1; m_s = 0; end
    end else if (tk && m_ticks() > 0 && pf_old == HT * VT - 1 && !e) begin
      m_run = 1'b0; m_s = 0;
    end else begin
      m_s++;
    end
    set   = m_run && run_old && m_pf() == VA * HT && pf_old != VA * HT;
    m_irq = set || (m_irq && !a);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.pce = pix_ce; o.hs = hsync; o.vs = vsync; o.von = video_on;
    o.x = px_x; o.y = px_y; o.le = line_end; o.fs = frame_start; o.busy = busy;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pce/hs/vs/von=%b%b%b%b x=%0d y=%0d le/fs/busy=%b%b%b, expected %b%b%b%b x=%0d y=%0d %b%b%b (t=%0t)",
               name, act.pce, act.hs, act.vs, act.von, act.x, act.y, act.le, act.fs, act.busy,
               exp.pce, exp.hs, exp.vs, exp.von, exp.x, exp.y, exp.le, exp.fs, exp.busy, $time);
    end
  endtask

  // One clock: drive inputs, step model on the edge, compare on the following negedge.
  task automatic cyc(input logic c, input logic e, input logic a);
    clr = c;
    en  = e;
`ifdef VGA_TIMING_IRQ_EN
    irq_ack = a;
`endif
    @(posedge clk);
    model_step(c, e, a);
    @(negedge clk);
    chk_obs("model", dut_obs(), model_out());
`ifdef VGA_TIMING_IRQ_EN
    chk("model_irq", int'(irq), int'(m_irq));
`endif
    cyc_n++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (fs_prev >= 0) fs_gap = cyc_n - fs_prev;
      fs_prev = cyc_n;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[11];

  initial begin
    obs_t ev;
    int   k, lx, ly, lo_cnt, min_x, max_x, base;
    clr = 1'b1;
    en  = 1'b0;
`ifdef VGA_TIMING_IRQ_EN
    irq_ack = 1'b0;
`endif
    //          clr en   n    x  y  busy hs vs von pce fs le
    tbl[0]  = '{1'b1, 1'b0, 3,   0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 18, 10, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 6,  13, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3,  14, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 180, 0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3,   0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].n) cyc(tbl[i].clr, tbl[i].en, 1'b0);
      ev.pce = tbl[i].pce; ev.hs = tbl[i].hs; ev.vs = tbl[i].vs; ev.von = tbl[i].von;
      ev.x = 10'(tbl[i].x); ev.y = 10'(tbl[i].y);
      ev.le = tbl[i].le; ev.fs = tbl[i].fs; ev.busy = tbl[i].busy;
      chk_obs($sformatf("vec%0d", i), dut_obs(), ev);
    end

    // Stop request mid-frame: the frame completes, then the sequencer idles.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    fs_prev = -1;
    cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    while (px_y != 10'd3 && k < 2 * FRAME) begin cyc(1'b0, 1'b1, 1'b0); k++; end
    chk("stop_reach_y3", int'(k < 2 * FRAME), 1);
    k = 0; lx = -1; ly = -1;
    while (busy && k < 2 * FRAME) begin
      lx = px_x; ly = px_y;
      cyc(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("stop_idle", int'(busy), 0);
    chk("stop_last_x", lx, HT - 1);
    chk("stop_last_y", ly, VT - 1);
    chk("stop_frame_len", fs_gap, FRAME);
    chk("stop_px_zero", int'(px_x) + int'(px_y), 0);

    // Stop then re-enable before the frame ends: no gap between frames.
    base = fs_cnt;
    fs_prev = -1;
    cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    while (px_y != 10'd2 && k < 2 * FRAME) begin cyc(1'b0, 1'b1, 1'b0); k++; end
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    k = 0;
    while (fs_cnt < base + 2 && k < 2 * FRAME) begin cyc(1'b0, 1'b1, 1'b0); k++; end
    chk("restart_reached", int'(fs_cnt >= base + 2), 1);
    chk("restart_frame_len", fs_gap, FRAME);
    chk("restart_busy", int'(busy), 1);

    // hsync window over one full line.
    k = 0;
    while (!line_end && k < 4 * HT * D) begin cyc(1'b0, 1'b1, 1'b0); k++; end
    lo_cnt = 0; min_x = 1023; max_x = -1;
    for (int j = 0; j < HT * D; j++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (!hsync) begin
        lo_cnt++;
        if (int'(px_x) < min_x) min_x = px_x;
        if (int'(px_x) > max_x) max_x = px_x;
      end
    end
    chk("hsync_low_clks", lo_cnt, HS * D);
    chk("hsync_first_x", min_x, HA + HF);
    chk("hsync_last_x", max_x, HA + HF + HS - 1);

`ifdef VGA_TIMING_IRQ_EN
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    while (!(px_y == 10'(VA) && px_x == 10'd0) && k < 2 * FRAME) begin
      cyc(1'b0, 1'b1, 1'b0); k++;
    end
    chk("irq_rise", int'(irq), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("irq_ack_clears", int'(irq), 0);
    k = 0;
    while (!(pix_ce && px_x == 10'(HT - 1) && px_y == 10'(VA - 1)) && k < 2 * FRAME) begin
      cyc(1'b0, 1'b1, 1'b0); k++;
    end
    cyc(1'b0, 1'b1, 1'b1);
    chk("irq_set_beats_ack", int'(irq), 1);
`endif

    // Randomized en levels, acks and rare resets against the model.
    for (int b = 0; b < 15; b++) begin
      logic lvl;
      int   len;
      lvl = ($urandom_range(0, 9) < 7);
      len = $urandom_range(50, 400);
      for (int j = 0; j < len; j++) begin
        cyc(($urandom_range(0, 999) == 0), lvl, ($urandom_range(0, 19) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
